// File: rtl/act_bw_engine.sv
`timescale 1ns/1ps
// act_bw_engine: elementwise activation-backward engine.
// Copies the G tensor header to D, then writes D[i] = f'(X[i]) * G[i] for every element.
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   go / done / err            level start, completion (held while go), bad-header flag
//   mode, leak_shift, clip_bits activation selection: 0 ReLU, 1 clipped ReLU, 2 leaky 2^-shift
//   g_base, x_base, d_base     region base word addresses
//   g_req/g_addr/g_rdata/g_done upstream-gradient read channel
//   x_req/x_addr/x_rdata/x_done forward-activation read channel
//   d_req/d_addr/d_wdata/d_wt/d_done output write channel (d_wt marks the last element)
module act_bw_engine #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_DIMS = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              go,
    input  logic [1:0]        mode,
    input  logic [4:0]        leak_shift,
    input  logic [DATA_W-1:0] clip_bits,
    input  logic [ADDR_W-1:0] g_base,
    input  logic [ADDR_W-1:0] x_base,
    input  logic [ADDR_W-1:0] d_base,
    output logic              done,
    output logic              err,
    output logic              g_req,
    output logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_rdata,
    input  logic              g_done,
    output logic              x_req,
    output logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_rdata,
    input  logic              x_done,
    output logic              d_req,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              d_wt,
    input  logic              d_done
);
    localparam int NW = $clog2(MAX_DIMS + 1);

    typedef enum logic [3:0] {
        IDLE, HDR_N, HDR_NW, HDR_D, HDR_DW, CHK, ELEM_RD, ELEM_WR, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     n_q, n_d, k_q, k_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, i_q, i_d;
    logic              err_q, err_d;
    logic              g_req_q, g_req_d, x_req_q, x_req_d, d_req_q, d_req_d;
    logic              d_wt_q, d_wt_d;
    logic              g_got_q, g_got_d, x_got_q, x_got_d;
    logic [ADDR_W-1:0] g_addr_q, g_addr_d, x_addr_q, x_addr_d, d_addr_q, d_addr_d;
    logic [DATA_W-1:0] g_dat_q, g_dat_d, x_dat_q, x_dat_d, d_wdata_q, d_wdata_d;

    logic [ADDR_W-1:0] e_off;
    logic [DATA_W-1:0] gv, xv, res;
    logic [7:0]        ex, sh8;
    logic [1:0]        m;
    logic              pass;
    logic              unused;

    // The clip threshold is a positive float, so only its magnitude bits matter.
    assign unused = clip_bits[DATA_W-1];

    // Word offset of the current element inside each region (header is 1+N words).
    assign e_off = ADDR_W'(n_q) + ADDR_W'(i_q) + ADDR_W'(1);

    // A channel that already completed supplies its captured word; otherwise the live bus.
    assign gv   = g_got_q ? g_dat_q : g_rdata;
    assign xv   = x_got_q ? x_dat_q : x_rdata;
    assign m    = (mode == 2'd3) ? 2'd0 : mode;
    assign ex   = gv[30:23];
    assign sh8  = {3'b000, leak_shift};
    assign pass = !xv[DATA_W-1] && (m != 2'd1 || xv[DATA_W-2:0] < clip_bits[DATA_W-2:0]);
    // Leaky slope is a pure exponent decrement; underflow flushes to a signed zero, Inf/NaN pass.
    assign res  = pass         ? gv :
                  (m != 2'd2)  ? '0 :
                  (ex == 8'hFF) ? gv :
                  (ex <= sh8)  ? {gv[DATA_W-1], {(DATA_W-1){1'b0}}} :
                                 {gv[DATA_W-1], ex - sh8, gv[22:0]};

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        i_d       = i_q;
        err_d     = err_q;
        g_req_d   = g_req_q & ~g_done;
        x_req_d   = x_req_q & ~x_done;
        d_req_d   = d_req_q & ~d_done;
        d_wt_d    = d_wt_q & ~d_done;
        g_addr_d  = g_addr_q;
        x_addr_d  = x_addr_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        g_got_d   = g_got_q;
        x_got_d   = x_got_q;
        g_dat_d   = g_dat_q;
        x_dat_d   = x_dat_q;
        case (state_q)
            IDLE: if (go) begin
                state_d  = HDR_N;
                g_req_d  = 1'b1;
                g_addr_d = g_base;
            end
            HDR_N: if (g_done) begin
                if (g_rdata == '0 || g_rdata > DATA_W'(MAX_DIMS)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    n_d       = NW'(g_rdata);
                    k_d       = NW'(1);
                    state_d   = HDR_NW;
                    d_req_d   = 1'b1;
                    d_addr_d  = d_base;
                    d_wdata_d = g_rdata;
                    d_wt_d    = 1'b0;
                end
            end
            HDR_NW: if (d_done) begin
                state_d  = HDR_D;
                g_req_d  = 1'b1;
                g_addr_d = g_base + ADDR_W'(k_q);
            end
            HDR_D: if (g_done) begin
                // The first dimension loads the count; later ones multiply (truncating).
                cnt_d     = (k_q == NW'(1)) ? CNT_W'(g_rdata) : cnt_q * CNT_W'(g_rdata);
                state_d   = HDR_DW;
                d_req_d   = 1'b1;
                d_addr_d  = d_base + ADDR_W'(k_q);
                d_wdata_d = g_rdata;
                d_wt_d    = 1'b0;
            end
            HDR_DW: if (d_done) begin
                if (k_q == n_q) begin
                    state_d = CHK;
                end else begin
                    k_d      = k_q + NW'(1);
                    state_d  = HDR_D;
                    g_req_d  = 1'b1;
                    g_addr_d = g_base + ADDR_W'(k_q) + ADDR_W'(1);
                end
            end
            CHK: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    i_d      = '0;
                    state_d  = ELEM_RD;
                    g_req_d  = 1'b1;
                    x_req_d  = 1'b1;
                    g_addr_d = g_base + ADDR_W'(n_q) + ADDR_W'(1);
                    x_addr_d = x_base + ADDR_W'(n_q) + ADDR_W'(1);
                end
            end
            ELEM_RD: begin
                if (g_done) begin
                    g_got_d = 1'b1;
                    g_dat_d = g_rdata;
                end
                if (x_done) begin
                    x_got_d = 1'b1;
                    x_dat_d = x_rdata;
                end
                if ((g_got_q | g_done) && (x_got_q | x_done)) begin
                    g_got_d   = 1'b0;
                    x_got_d   = 1'b0;
                    state_d   = ELEM_WR;
                    d_req_d   = 1'b1;
                    d_addr_d  = d_base + e_off;
                    d_wdata_d = res;
                    d_wt_d    = (i_q == cnt_q - CNT_W'(1));
                end
            end
            ELEM_WR: if (d_done) begin
                if (i_q + CNT_W'(1) == cnt_q) begin
                    state_d = DONE;
                end else begin
                    i_d      = i_q + CNT_W'(1);
                    state_d  = ELEM_RD;
                    g_req_d  = 1'b1;
                    x_req_d  = 1'b1;
                    g_addr_d = g_base + e_off + ADDR_W'(1);
                    x_addr_d = x_base + e_off + ADDR_W'(1);
                end
            end
            DONE: if (!go) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            n_q       <= '0;
            k_q       <= '0;
            cnt_q     <= '0;
            i_q       <= '0;
            err_q     <= 1'b0;
            g_req_q   <= 1'b0;
            x_req_q   <= 1'b0;
            d_req_q   <= 1'b0;
            d_wt_q    <= 1'b0;
            g_addr_q  <= '0;
            x_addr_q  <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            g_got_q   <= 1'b0;
            x_got_q   <= 1'b0;
            g_dat_q   <= '0;
            x_dat_q   <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            i_q       <= i_d;
            err_q     <= err_d;
            g_req_q   <= g_req_d;
            x_req_q   <= x_req_d;
            d_req_q   <= d_req_d;
            d_wt_q    <= d_wt_d;
            g_addr_q  <= g_addr_d;
            x_addr_q  <= x_addr_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            g_got_q   <= g_got_d;
            x_got_q   <= x_got_d;
            g_dat_q   <= g_dat_d;
            x_dat_q   <= x_dat_d;
        end
    end

    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign g_req   = g_req_q;
    assign g_addr  = g_addr_q;
    assign x_req   = x_req_q;
    assign x_addr  = x_addr_q;
    assign d_req   = d_req_q;
    assign d_addr  = d_addr_q;
    assign d_wdata = d_wdata_q;
    assign d_wt    = d_wt_q;
endmodule

// File: tb/tb_act_bw_engine.sv
`timescale 1ns/1ps
// tb_act_bw_engine: randomized self-checking bench for act_bw_engine with memory responders
// and a specification-level reference model of the expected D write stream.
module tb_act_bw_engine;
    localparam int GB = 100, XB = 300, DB = 600;

    logic        clk = 1'b0, rst_l = 1'b0, go = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [4:0]  leak_shift = 5'd0;
    logic [31:0] clip_bits = 32'h0;
    logic [31:0] g_base = GB, x_base = XB, d_base = DB;
    logic        done, err, g_req, x_req, d_req, d_wt;
    logic [31:0] g_addr, x_addr, d_addr, d_wdata;
    logic [31:0] g_rdata = 32'h0, x_rdata = 32'h0;
    logic        g_done = 1'b0, x_done = 1'b0, d_done = 1'b0;

    logic [31:0] gmem [0:1023];
    logic [31:0] xmem [0:1023];
    logic [31:0] dmem [0:1023];
    int g_lat = -1, x_lat = -1, d_lat = -1;
    int g_reads = 0, x_reads = 0;
    logic [31:0] wa[$], wd[$];
    logic        ww[$];
    logic [31:0] hq[$], ge[$], xe[$];
    logic [31:0] ea[$], ed[$];
    logic        ew[$];
    logic        exp_err;
    int exp_gr, exp_xr;
    int checks = 0, failures = 0, proto_err = 0;

    always #5 clk = ~clk;

    act_bw_engine dut (
        .clk(clk), .rst_l(rst_l), .go(go), .mode(mode), .leak_shift(leak_shift),
        .clip_bits(clip_bits), .g_base(g_base), .x_base(x_base), .d_base(d_base),
        .done(done), .err(err),
        .g_req(g_req), .g_addr(g_addr), .g_rdata(g_rdata), .g_done(g_done),
        .x_req(x_req), .x_addr(x_addr), .x_rdata(x_rdata), .x_done(x_done),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wt(d_wt), .d_done(d_done)
    );

    initial forever begin
        int n;
        @(posedge clk); #1;
        if (g_req) begin
            n = (g_lat >= 0) ? g_lat : $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
            if (g_req) begin
                g_rdata = gmem[g_addr[9:0]]; g_done = 1'b1; g_reads++;
                @(posedge clk); #1 g_done = 1'b0;
            end
        end
    end

    initial forever begin
        int n;
        @(posedge clk); #1;
        if (x_req) begin
            n = (x_lat >= 0) ? x_lat : $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
            if (x_req) begin
                x_rdata = xmem[x_addr[9:0]]; x_done = 1'b1; x_reads++;
                @(posedge clk); #1 x_done = 1'b0;
            end
        end
    end

    initial forever begin
        int n;
        @(posedge clk); #1;
        if (d_req) begin
            n = (d_lat >= 0) ? d_lat : $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
            if (d_req) begin
                dmem[d_addr[9:0]] = d_wdata;
                wa.push_back(d_addr); wd.push_back(d_wdata); ww.push_back(d_wt);
                d_done = 1'b1;
                @(posedge clk); #1 d_done = 1'b0;
            end
        end
    end

    // Protocol watch: addr/wdata stable while req holds, and req low the cycle after done.
    logic pg = 0, px = 0, pd = 0, pgd = 0, pxd = 0, pdd = 0;
    logic [31:0] pga = 0, pxa = 0, pda = 0, pdw = 0;
    always @(negedge clk) begin
        if (rst_l) begin
            if (g_req && pg && g_addr !== pga) proto_err++;
            if (x_req && px && x_addr !== pxa) proto_err++;
            if (d_req && pd && (d_addr !== pda || d_wdata !== pdw)) proto_err++;
            if ((g_req && pgd) || (x_req && pxd) || (d_req && pdd)) proto_err++;
        end
        pg = g_req; px = x_req; pd = d_req; pgd = g_done; pxd = x_done; pdd = d_done;
        pga = g_addr; pxa = x_addr; pda = d_addr; pdw = d_wdata;
    end

    function automatic logic [31:0] ref_f(input logic [1:0] md, input logic [4:0] sh,
                                          input logic [31:0] cl, input logic [31:0] x,
                                          input logic [31:0] g);
        int e = int'(g[30:23]);
        if (md == 2'd3) md = 2'd0;
        if (!x[31] && !(md == 2'd1 && x[30:0] >= cl[30:0])) return g;
        if (md != 2'd2) return 32'h0;
        if (e == 255) return g;
        if (e <= int'(sh)) return {g[31], 31'h0};
        return {g[31], 8'(e - int'(sh)), g[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0: e = 8'd0;
            1: e = 8'd1;
            2: e = 8'($urandom_range(0, 31));
            3: e = 8'hFF;
            default: e = 8'($urandom_range(0, 254));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Expected D stream: header words copied, then one result per element, last one write-through.
    function automatic void build_exp();
        logic [31:0] cnt = 32'd1;
        int n = int'(hq[0]);
        ea.delete(); ed.delete(); ew.delete();
        exp_err = (hq[0] == 0 || hq[0] > 4);
        exp_gr = 1; exp_xr = 0;
        if (exp_err) return;
        for (int k = 1; k <= n; k++) cnt = cnt * hq[k];
        for (int j = 0; j <= n; j++) begin ea.push_back(DB + j); ed.push_back(hq[j]); ew.push_back(1'b0); end
        for (int i = 0; i < int'(cnt); i++) begin
            ea.push_back(DB + 1 + n + i);
            ed.push_back(ref_f(mode, leak_shift, clip_bits, xe[i], ge[i]));
            ew.push_back(i == int'(cnt) - 1);
        end
        exp_gr = 1 + n + int'(cnt); exp_xr = int'(cnt);
    endfunction

    task automatic load();
        for (int j = 0; j < 1024; j++) begin gmem[j] = 32'hDEAD0000; xmem[j] = 32'hBEEF0000; dmem[j] = 32'hA5A5A5A5; end
        for (int j = 0; j < hq.size(); j++) begin gmem[GB + j] = hq[j]; xmem[XB + j] = hq[j]; end
        for (int i = 0; i < ge.size(); i++) gmem[GB + hq.size() + i] = ge[i];
        for (int i = 0; i < xe.size(); i++) xmem[XB + hq.size() + i] = xe[i];
        build_exp();
    endtask

    task automatic run_dut();
        int cyc = 0;
        wa.delete(); wd.delete(); ww.delete(); g_reads = 0; x_reads = 0;
        go = 1'b1;
        while (done !== 1'b1 && cyc < 4000) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL run_timeout done=%b required=1", done); end
    endtask

    task automatic end_run();
        go = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({g_req, x_req, d_req, done, err, d_wt} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b required=000000", {g_req, x_req, d_req, done, err, d_wt});
        end
        checks++;
        if ({g_addr, x_addr, d_addr, d_wdata} !== 128'b0) begin
            failures++; $display("FAIL reset_data got=%h %h %h %h required=0", g_addr, x_addr, d_addr, d_wdata);
        end
        rst_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        logic [31:0] want [6] = '{32'd1, 32'd4, 32'h40400000, 32'h0, 32'h40A00000, 32'h0};
        mode = 2'd0;
        hq = '{32'd1, 32'd4};
        xe = '{32'h3F800000, 32'hC0000000, 32'h00000000, 32'h80000000};
        ge = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        load();
        run_dut();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL relu_err got=%b required=0", err); end
        checks++; if (wa.size() != 6) begin failures++; $display("FAIL relu_nwr got=%0d required=6", wa.size()); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (dmem[DB + j] !== want[j]) begin failures++; $display("FAIL relu_d%0d got=%h required=%h", j, dmem[DB + j], want[j]); end
        end
        for (int j = 0; j < wa.size() && j < 6; j++) begin
            checks++;
            if (ww[j] !== (j == 5)) begin failures++; $display("FAIL relu_wt%0d got=%b required=%b", j, ww[j], j == 5); end
        end
        end_run();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL relu_done_drop got=%b required=0", done); end
    endtask

    task automatic test_clip();
        logic [31:0] want [3] = '{32'h3F800000, 32'h0, 32'h0};
        mode = 2'd1; clip_bits = 32'h40C00000;
        hq = '{32'd1, 32'd3};
        xe = '{32'h40A00000, 32'h40C00000, 32'h40E00000};
        ge = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        load();
        run_dut();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dmem[DB + 2 + i] !== want[i]) begin failures++; $display("FAIL clip_e%0d got=%h required=%h", i, dmem[DB + 2 + i], want[i]); end
        end
        checks++; if (wa.size() != ea.size()) begin failures++; $display("FAIL clip_nwr got=%0d required=%0d", wa.size(), ea.size()); end
        end_run();
    endtask

    task automatic test_leaky();
        logic [31:0] want [3] = '{32'h40000000, 32'h80000000, 32'h7F800000};
        mode = 2'd2; leak_shift = 5'd2;
        hq = '{32'd1, 32'd3};
        xe = '{32'hBF800000, 32'hBF800000, 32'hBF800000};
        ge = '{32'h41000000, 32'h80800000, 32'h7F800000};
        load();
        run_dut();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dmem[DB + 2 + i] !== want[i]) begin failures++; $display("FAIL leaky_e%0d got=%h required=%h", i, dmem[DB + 2 + i], want[i]); end
        end
        for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
            checks++;
            if ({wa[j], wd[j], ww[j]} !== {ea[j], ed[j], ew[j]}) begin
                failures++; $display("FAIL leaky_wr%0d got a=%0d d=%h wt=%b required a=%0d d=%h wt=%b", j, wa[j], wd[j], ww[j], ea[j], ed[j], ew[j]);
            end
        end
        end_run();
    endtask

    task automatic test_header();
        for (int c = 0; c < 3; c++) begin
            mode = 2'd0;
            hq = (c == 0) ? '{32'd2, 32'd2, 32'd3} : (c == 1) ? '{32'd0} : '{32'd5};
            ge.delete(); xe.delete();
            for (int i = 0; i < 6; i++) begin ge.push_back(rnd_f()); xe.push_back(rnd_f()); end
            load();
            run_dut();
            checks++; if (err !== exp_err) begin failures++; $display("FAIL hdr%0d_err got=%b required=%b", c, err, exp_err); end
            checks++; if (wa.size() != ea.size()) begin failures++; $display("FAIL hdr%0d_nwr got=%0d required=%0d", c, wa.size(), ea.size()); end
            for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
                checks++;
                if ({wa[j], wd[j], ww[j]} !== {ea[j], ed[j], ew[j]}) begin
                    failures++; $display("FAIL hdr%0d_wr%0d got a=%0d d=%h wt=%b required a=%0d d=%h wt=%b", c, j, wa[j], wd[j], ww[j], ea[j], ed[j], ew[j]);
                end
            end
            end_run();
            checks++; if (err !== 1'b0) begin failures++; $display("FAIL hdr%0d_err_clear got=%b required=0", c, err); end
        end
    endtask

    task automatic test_skew();
        int gl [3] = '{4, 2, 1};
        int xl [3] = '{1, 2, 4};
        for (int c = 0; c < 3; c++) begin
            g_lat = gl[c]; x_lat = xl[c]; mode = 2'd0;
            hq = '{32'd1, 32'd4};
            ge.delete(); xe.delete();
            for (int i = 0; i < 4; i++) begin ge.push_back(rnd_f()); xe.push_back(rnd_f()); end
            load();
            run_dut();
            checks++;
            if (g_reads != exp_gr || x_reads != exp_xr) begin
                failures++; $display("FAIL skew%0d_reads got g=%0d x=%0d required g=%0d x=%0d", c, g_reads, x_reads, exp_gr, exp_xr);
            end
            for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
                checks++;
                if ({wa[j], wd[j], ww[j]} !== {ea[j], ed[j], ew[j]}) begin
                    failures++; $display("FAIL skew%0d_wr%0d got a=%0d d=%h wt=%b required a=%0d d=%h wt=%b", c, j, wa[j], wd[j], ww[j], ea[j], ed[j], ew[j]);
                end
            end
            end_run();
        end
        g_lat = -1; x_lat = -1;
    endtask

    task automatic test_zero_dim();
        mode = 2'd0;
        hq = '{32'd1, 32'd0};
        ge = '{32'h3F800000}; xe = '{32'h3F800000};
        load();
        run_dut();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL zdim_err got=%b required=0", err); end
        checks++;
        if (wa.size() != 2 || x_reads != 0 || g_reads != 2) begin
            failures++; $display("FAIL zdim_access got wr=%0d gr=%0d xr=%0d required wr=2 gr=2 xr=0", wa.size(), g_reads, x_reads);
        end
        checks++;
        if (dmem[DB] !== 32'd1 || dmem[DB + 1] !== 32'd0) begin
            failures++; $display("FAIL zdim_hdr got=%h %h required=1 0", dmem[DB], dmem[DB + 1]);
        end
        end_run();
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 3);
            int cnt = 1;
            mode = 2'($urandom_range(0, 3)); leak_shift = 5'($urandom_range(0, 31));
            clip_bits = {1'b0, 31'($urandom)};
            hq = '{32'(n)};
            for (int k = 0; k < n; k++) begin hq.push_back(32'($urandom_range(1, 3))); cnt = cnt * int'(hq[k + 1]); end
            ge.delete(); xe.delete();
            for (int i = 0; i < cnt; i++) begin ge.push_back(rnd_f()); xe.push_back(rnd_f()); end
            load();
            run_dut();
            checks++; if (wa.size() != ea.size()) begin failures++; $display("FAIL rnd%0d_nwr got=%0d required=%0d", r, wa.size(), ea.size()); end
            for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
                checks++;
                if ({wa[j], wd[j], ww[j]} !== {ea[j], ed[j], ew[j]}) begin
                    failures++; $display("FAIL rnd%0d_wr%0d m=%0d got a=%0d d=%h wt=%b required a=%0d d=%h wt=%b", r, j, mode, wa[j], wd[j], ww[j], ea[j], ed[j], ew[j]);
                end
            end
            end_run();
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc = 0;
        mode = 2'd0; d_lat = 6;
        hq = '{32'd1, 32'd4};
        ge = '{32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
        xe = '{32'h3F800000, 32'hC0000000, 32'h00000000, 32'h80000000};
        load();
        go = 1'b1;
        while (!(d_req && d_addr >= DB + 2) && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (!(d_req && d_addr >= DB + 2)) begin failures++; $display("FAIL rstmid_reach got d_req=%b required=1", d_req); end
        #2 rst_l = 1'b0;
        #1;
        checks++;
        if ({g_req, x_req, d_req, done, err, d_wt} !== 6'b0) begin
            failures++; $display("FAIL rstmid_async got=%b required=000000", {g_req, x_req, d_req, done, err, d_wt});
        end
        go = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1; d_lat = -1;
        repeat (12) @(posedge clk);
        #1;
        load();
        run_dut();
        checks++; if (wa.size() != ea.size()) begin failures++; $display("FAIL rstmid_nwr got=%0d required=%0d", wa.size(), ea.size()); end
        for (int j = 0; j < wa.size() && j < ea.size(); j++) begin
            checks++;
            if ({wa[j], wd[j], ww[j]} !== {ea[j], ed[j], ew[j]}) begin
                failures++; $display("FAIL rstmid_wr%0d got a=%0d d=%h wt=%b required a=%0d d=%h wt=%b", j, wa[j], wd[j], ww[j], ea[j], ed[j], ew[j]);
            end
        end
        end_run();
    endtask

    initial begin
        test_reset();
        test_relu();
        test_clip();
        test_leaky();
        test_header();
        test_skew();
        test_zero_dim();
        test_random();
        test_reset_mid_run();
        checks++;
        if (proto_err != 0) begin failures++; $display("FAIL handshake_protocol got=%0d violations required=0", proto_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/act_bw_engine.md
Name: act_bw_engine

Overview:
- Parametrised elementwise activation-backward engine; successor of the single-mode ReLU backward unit.
- Copies the upstream-gradient tensor header to the output region, then computes out[i] = f'(x[i]) * g[i] for every element.
- Three memory channels: G (upstream gradient, read), X (forward activation input, read), D (output, write).
- Mode is selectable per run: ReLU, clipped ReLU, or leaky ReLU with a power-of-two slope. Sits beside the other FPU-side layer engines, driven by the worker's go/done sequencer.

Parameters:
DATA_W, 32, word width; IEEE-754 single (sign bit 31, exponent 30:23)
ADDR_W, 32, memory word-address width
MAX_DIMS, 4, maximum tensor rank accepted in header
CNT_W, 32, element counter width (product truncated to CNT_W)

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
go  in  1  start; level, held high until done observed
mode  in  2  0=ReLU, 1=clipped ReLU, 2=leaky pow2, 3=reserved (treated as 0)
leak_shift  in  5  leaky slope 2^-leak_shift, mode 2 only
clip_bits  in  DATA_W  clip threshold as float bit pattern (positive), mode 1 only
g_base, x_base, d_base  in  ADDR_W each  region base word addresses
done  out  1  run complete, held while go high
err  out  1  bad header (ndim 0 or >MAX_DIMS), valid while done
g_req, x_req  out  1 each  read request
g_addr, x_addr  out  ADDR_W each  read address
g_rdata, x_rdata  in  DATA_W each  read data, valid when *_done
g_done, x_done  in  1 each  single-cycle completion pulse
d_req  out  1  write request
d_addr  out  ADDR_W  write address
d_wdata  out  DATA_W  write data
d_wt  out  1  write-through, asserted with last element write
d_done  in  1  write completion pulse

Behaviour:
- Reset: state IDLE; all req, done, err, d_wt = 0; addr, wdata = 0. Reset mid-run aborts immediately, drops all req; no resume.
- Handshake: req asserted with stable addr/wdata until the *_done pulse; req deasserted the cycle after done; at least one idle cycle between requests on the same channel. rdata is captured on the done cycle.
- Header layout in G: word 0 = ndim N, words 1..N = dims. X has an identical layout; only its element area is read. Elements start at base+1+N in all three regions.
- States and transitions:
  - IDLE: go -> HDR_N.
  - HDR_N: read G[g_base]; latch N. If N==0 or N>MAX_DIMS: err=1, go to DONE without writing anything. Otherwise write N to D[d_base] -> HDR_D.
  - HDR_D: for k=1..N, read G[g_base+k] then write to D[d_base+k]; count = count*dim (first dim loads count). -> CHK.
  - CHK: count==0 -> DONE; else -> ELEM_RD.
  - ELEM_RD: issue G and X reads together at element index i. Each channel drops its own req on its done; the two done pulses may arrive in the same cycle or in either order. -> ELEM_WR when both are captured.
  - ELEM_WR: write result to D; d_wt=1 iff i==count-1. On d_done: i++; i==count -> DONE, else -> ELEM_RD.
  - DONE: done=1; go low -> IDLE (err cleared on leaving).
- Result rule (x = X word, g = G word):
  - mode 0: pass g if x[31]==0 (+0 passes), else +0.
  - mode 1: pass g if x[31]==0 and x[30:0] < clip_bits[30:0] (unsigned compare), else +0.
  - mode 2: pass g if x[31]==0. Otherwise keep the sign of g with exponent e-leak_shift. If e <= leak_shift, output a signed zero. If e==255 (Inf/NaN), pass g unchanged.
- Latency per element: one read handshake plus one write handshake, no overlap.
- go dropped mid-run is ignored; the run completes, then DONE exits immediately.

Test Plan:
- ReLU: mode0, header N=1 dim=4, X={1.0,-2.0,+0,-0}, G={3,4,5,6} -> D hdr {1,4}, D elems {3,0,5,0}; d_wt only on 4th write; done=1.
- Clip: mode1, clip_bits=0x40C00000, X={5.0,6.0,7.0}, G={1,1,1} -> D elems {1.0,0,0}.
- Leaky: mode2, shift=2, X={-1.0,-1.0,-1.0}, G={8.0 (0x41000000), -0x00800000, +Inf} -> {2.0 (0x40000000), signed zero 0x80000000, +Inf}.
- Header: N=2 dims {2,3} -> 6 element writes, D hdr {2,2,3}. N=0 -> err=1, no D writes. N=5 -> err=1.
- Handshake skew: x_done 3 cycles before g_done, then same-cycle pulses -> correct pairing, no duplicate reqs. Zero-dim header {1,0} -> header copied, no element access.
- Reset asserted during ELEM_WR -> all req low asynchronously; a fresh go reruns from the header correctly.
